key_event_gen: RTL and testbench

Per-operator key event source for the OPL3 operator pipeline. It accepts asynchronous host key-on/key-off writes and stores each level change as a pending event per operator. When the sample sweep reaches that operator, it emits a single-sample `key_on_pulse_p0` or `key_off_pulse_p0`. It drives the envelope generator's key pulse inputs, aligned with the same `bank_num`/`op_num`/`sample_clk_en` slot.

---
 rtl/opl3_pkg.sv | 19 +
 rtl/key_event_slot.sv | 71 +++++++
 rtl/key_event_gen.sv | 77 +++++++
 tb/tb_key_event_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// opl3_pkg: shared OPL3 constants and types.
//   NUM_BANKS / NUM_OPERATORS_PER_BANK : operator array geometry.
//   BANK_NUM_WIDTH / OP_NUM_WIDTH      : index widths for bank and operator.
//   key_evt_t                          : per-operator key flags
//                                        {kon, pend_on, pend_off}.
package opl3_pkg;

    localparam int NUM_BANKS              = 2;
    localparam int NUM_OPERATORS_PER_BANK = 18;
    localparam int BANK_NUM_WIDTH         = $clog2(NUM_BANKS);
    localparam int OP_NUM_WIDTH           = $clog2(NUM_OPERATORS_PER_BANK);

    typedef struct packed {
        logic kon;       // stored key level
        logic pend_on;   // key-on waiting for its slot
        logic pend_off;  // key-off waiting for its slot
    } key_evt_t;

endpackage

// File: rtl/key_event_slot.sv
// key_event_slot: key flag register for one operator.
// Merges a host write and a sweep service hitting the same cycle as
// write(service(current)), so a write is never lost and never emitted in
// the cycle it arrives.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   wr_hit       : host key write addressed to this operator
//   wr_val       : requested key level (1 = on)
//   svc_hit      : sweep is servicing this operator this cycle
//   kon          : stored key level
//   on_pulse     : key-on emitted this cycle
//   off_pulse    : key-off emitted this cycle
// Build option OPL3_KEY_OFF_DEFER_EN: when defined, a key-off written while a
// key-on is still pending is queued behind it instead of replacing it.
module key_event_slot
    import opl3_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wr_hit,
    input  logic wr_val,
    input  logic svc_hit,
    output logic kon,
    output logic on_pulse,
    output logic off_pulse
);

    key_evt_t cur;
    key_evt_t nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        // Key-on has priority, so at most one pulse per service.
        on_pulse  = svc_hit & cur.pend_on;
        off_pulse = svc_hit & ~cur.pend_on & cur.pend_off;

        nxt = cur;
        if (on_pulse) begin
            nxt.pend_on = 1'b0;
        end else if (off_pulse) begin
            nxt.pend_off = 1'b0;
        end

        // Write applied on top of the serviced state; same level is a no-op.
        if (wr_hit && (wr_val != cur.kon)) begin
            if (wr_val) begin
                nxt.kon      = 1'b1;
                nxt.pend_on  = 1'b1;
                nxt.pend_off = 1'b0;
            end else begin
                nxt.kon      = 1'b0;
                nxt.pend_off = 1'b1;
`ifdef OPL3_KEY_OFF_DEFER_EN
                // Pending key-on stays queued ahead of this key-off.
`else
                nxt.pend_on  = 1'b0;
`endif
            end
        end
    end

    assign kon = cur.kon;

endmodule

// File: rtl/key_event_gen.sv
// key_event_gen: per-operator key event source for the OPL3 operator
// pipeline. Host key writes are stored as pending events per operator and
// released as single-cycle pulses when the sample sweep reaches that slot.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sample_clk_en     : slot service strobe, qualifies bank_num/op_num
//   bank_num, op_num  : slot being swept
//   key_wr            : host key write strobe (one cycle)
//   key_wr_bank/op    : operator addressed by the write
//   key_wr_val        : requested key level (1 = on)
//   key_on_pulse_p0   : key-on event for the swept slot
//   key_off_pulse_p0  : key-off event for the swept slot
//   key_state_p0      : stored key level of the swept slot
// Build option OPL3_KEY_OFF_DEFER_EN (in key_event_slot): queue a key-off
// behind a still-pending key-on instead of letting the latest event win.
module key_event_gen
    import opl3_pkg::*;
#(
    parameter int NUM_BANKS              = opl3_pkg::NUM_BANKS,
    parameter int NUM_OPERATORS_PER_BANK = opl3_pkg::NUM_OPERATORS_PER_BANK
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_clk_en,
    input  logic [BANK_NUM_WIDTH-1:0] bank_num,
    input  logic [OP_NUM_WIDTH-1:0]   op_num,
    input  logic                      key_wr,
    input  logic [BANK_NUM_WIDTH-1:0] key_wr_bank,
    input  logic [OP_NUM_WIDTH-1:0]   key_wr_op,
    input  logic                      key_wr_val,
    output logic                      key_on_pulse_p0,
    output logic                      key_off_pulse_p0,
    output logic                      key_state_p0
);

    localparam int NUM_SLOTS = NUM_BANKS * NUM_OPERATORS_PER_BANK;

    logic [NUM_SLOTS-1:0] on_vec;
    logic [NUM_SLOTS-1:0] off_vec;
    logic [NUM_SLOTS-1:0] state_vec;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar o = 0; o < NUM_OPERATORS_PER_BANK; o++) begin : g_op
            logic wr_hit;
            logic svc_hit;
            logic slot_sel;
            logic slot_kon;

            // Out-of-range indices never match any generated slot, so such
            // writes and services fall through without effect.
            assign wr_hit   = key_wr && (int'(key_wr_bank) == b) &&
                              (int'(key_wr_op) == o);
            assign slot_sel = (int'(bank_num) == b) && (int'(op_num) == o);
            assign svc_hit  = sample_clk_en && slot_sel;

            key_event_slot u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .wr_hit    (wr_hit),
                .wr_val    (key_wr_val),
                .svc_hit   (svc_hit),
                .kon       (slot_kon),
                .on_pulse  (on_vec[b*NUM_OPERATORS_PER_BANK + o]),
                .off_pulse (off_vec[b*NUM_OPERATORS_PER_BANK + o])
            );

            assign state_vec[b*NUM_OPERATORS_PER_BANK + o] = slot_sel && slot_kon;
        end
    end

    // At most one slot is selected, so OR-reduction acts as the output mux.
    // Pulses are already gated by sample_clk_en inside each slot.
    assign key_on_pulse_p0  = |on_vec;
    assign key_off_pulse_p0 = |off_vec;
    assign key_state_p0     = |state_vec;

endmodule

// File: tb/tb_key_event_gen.sv
module tb_key_event_gen;

    logic       clk;
    logic       rst_n;
    logic       sample_clk_en;
    logic [0:0] bank_num;
    logic [4:0] op_num;
    logic       key_wr;
    logic [0:0] key_wr_bank;
    logic [4:0] key_wr_op;
    logic       key_wr_val;
    logic       key_on_pulse_p0;
    logic       key_off_pulse_p0;
    logic       key_state_p0;

    int errors = 0;
    int checks = 0;

    // Sweep results
    int sw_on, sw_off, sw_both;
    int sw_on_b, sw_on_o, sw_off_b, sw_off_o;

    key_event_gen dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sample_clk_en    (sample_clk_en),
        .bank_num         (bank_num),
        .op_num           (op_num),
        .key_wr           (key_wr),
        .key_wr_bank      (key_wr_bank),
        .key_wr_op        (key_wr_op),
        .key_wr_val       (key_wr_val),
        .key_on_pulse_p0  (key_on_pulse_p0),
        .key_off_pulse_p0 (key_off_pulse_p0),
        .key_state_p0     (key_state_p0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input int b, input int o, input logic v);
        key_wr      = 1'b1;
        key_wr_bank = 1'(b);
        key_wr_op   = 5'(o);
        key_wr_val  = v;
        @(posedge clk); #1;
        key_wr      = 1'b0;
    endtask

    // Full sweep over every in-range slot, one slot per cycle.
    task automatic sweep();
        sw_on = 0; sw_off = 0; sw_both = 0;
        sw_on_b = -1; sw_on_o = -1; sw_off_b = -1; sw_off_o = -1;
        for (int b = 0; b < 2; b++) begin
            for (int o = 0; o < 18; o++) begin
                bank_num      = 1'(b);
                op_num        = 5'(o);
                sample_clk_en = 1'b1;
                @(negedge clk);
                if (key_on_pulse_p0 && key_off_pulse_p0) sw_both++;
                if (key_on_pulse_p0) begin
                    sw_on++; sw_on_b = b; sw_on_o = o;
                end
                if (key_off_pulse_p0) begin
                    sw_off++; sw_off_b = b; sw_off_o = o;
                end
                @(posedge clk); #1;
            end
        end
        sample_clk_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (key_on_pulse_p0 !== 1'b0) begin
            errors++; $display("FAIL reset_on: got %b want 0", key_on_pulse_p0);
        end
        checks++;
        if (key_off_pulse_p0 !== 1'b0) begin
            errors++; $display("FAIL reset_off: got %b want 0", key_off_pulse_p0);
        end
        checks++;
        if (key_state_p0 !== 1'b0) begin
            errors++; $display("FAIL reset_state: got %b want 0", key_state_p0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sweep();
        checks++;
        if (sw_on + sw_off !== 0) begin
            errors++; $display("FAIL reset_sweep: got on=%0d off=%0d want 0/0", sw_on, sw_off);
        end
    endtask

    task automatic test_key_on();
        wr(0, 5, 1'b1);
        sweep();
        checks++;
        if (sw_on !== 1 || sw_on_b !== 0 || sw_on_o !== 5) begin
            errors++; $display("FAIL on_pulse: got n=%0d at (%0d,%0d) want 1 at (0,5)", sw_on, sw_on_b, sw_on_o);
        end
        checks++;
        if (sw_off !== 0) begin
            errors++; $display("FAIL on_no_off: got %0d want 0", sw_off);
        end
        sweep();
        checks++;
        if (sw_on + sw_off !== 0) begin
            errors++; $display("FAIL on_resweep: got on=%0d off=%0d want 0/0", sw_on, sw_off);
        end
        bank_num = 1'b0; op_num = 5'd5; sample_clk_en = 1'b0;
        @(negedge clk);
        checks++;
        if (key_state_p0 !== 1'b1) begin
            errors++; $display("FAIL on_state: got %b want 1", key_state_p0);
        end
        op_num = 5'd6;
        #1;
        checks++;
        if (key_state_p0 !== 1'b0) begin
            errors++; $display("FAIL other_state: got %b want 0", key_state_p0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_key_off();
        wr(0, 5, 1'b0);
        sweep();
        checks++;
        if (sw_off !== 1 || sw_off_b !== 0 || sw_off_o !== 5 || sw_on !== 0) begin
            errors++; $display("FAIL off_pulse: got off=%0d at (%0d,%0d) on=%0d want 1 at (0,5) on=0",
                               sw_off, sw_off_b, sw_off_o, sw_on);
        end
        wr(0, 5, 1'b0);
        sweep();
        checks++;
        if (sw_on + sw_off !== 0) begin
            errors++; $display("FAIL repeat_off: got on=%0d off=%0d want 0/0", sw_on, sw_off);
        end
        bank_num = 1'b0; op_num = 5'd5;
        @(negedge clk);
        checks++;
        if (key_state_p0 !== 1'b0) begin
            errors++; $display("FAIL off_state: got %b want 0", key_state_p0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_on_off_burst();
        int exp_on1, exp_off1, exp_on2, exp_off2;
`ifdef OPL3_KEY_OFF_DEFER_EN
        exp_on1 = 1; exp_off1 = 0; exp_on2 = 0; exp_off2 = 1;
`else
        exp_on1 = 0; exp_off1 = 1; exp_on2 = 0; exp_off2 = 0;
`endif
        wr(1, 17, 1'b1);
        wr(1, 17, 1'b0);
        sweep();
        checks++;
        if (sw_on !== exp_on1 || sw_off !== exp_off1) begin
            errors++; $display("FAIL burst_sweep1: got on=%0d off=%0d want %0d/%0d", sw_on, sw_off, exp_on1, exp_off1);
        end
        checks++;
        if ((sw_on > 0 && (sw_on_b !== 1 || sw_on_o !== 17)) ||
            (sw_off > 0 && (sw_off_b !== 1 || sw_off_o !== 17))) begin
            errors++; $display("FAIL burst_slot1: got on(%0d,%0d) off(%0d,%0d) want (1,17)", sw_on_b, sw_on_o, sw_off_b, sw_off_o);
        end
        sweep();
        checks++;
        if (sw_on !== exp_on2 || sw_off !== exp_off2) begin
            errors++; $display("FAIL burst_sweep2: got on=%0d off=%0d want %0d/%0d", sw_on, sw_off, exp_on2, exp_off2);
        end
    endtask

    task automatic test_same_cycle();
        wr(0, 3, 1'b1);
        sweep();
        wr(0, 3, 1'b0);
        // Service (0,3) with pend_off=1 while writing it on.
        bank_num = 1'b0; op_num = 5'd3; sample_clk_en = 1'b1;
        key_wr = 1'b1; key_wr_bank = 1'b0; key_wr_op = 5'd3; key_wr_val = 1'b1;
        @(negedge clk);
        checks++;
        if (key_off_pulse_p0 !== 1'b1 || key_on_pulse_p0 !== 1'b0) begin
            errors++; $display("FAIL same_cycle_pulse: got on=%b off=%b want on=0 off=1", key_on_pulse_p0, key_off_pulse_p0);
        end
        @(posedge clk); #1;
        key_wr = 1'b0; sample_clk_en = 1'b0;
        sweep();
        checks++;
        if (sw_on !== 1 || sw_on_b !== 0 || sw_on_o !== 3 || sw_off !== 0) begin
            errors++; $display("FAIL same_cycle_next: got on=%0d at (%0d,%0d) off=%0d want 1 at (0,3) off=0",
                               sw_on, sw_on_b, sw_on_o, sw_off);
        end
    endtask

    task automatic test_back_to_back();
        wr(0, 1, 1'b1);
        wr(0, 2, 1'b1);
        wr(1, 0, 1'b1);
        sweep();
        checks++;
        if (sw_on !== 3 || sw_off !== 0 || sw_both !== 0) begin
            errors++; $display("FAIL back_to_back: got on=%0d off=%0d both=%0d want 3/0/0", sw_on, sw_off, sw_both);
        end
    endtask

    task automatic test_out_of_range();
        wr(0, 18, 1'b1);
        wr(1, 20, 1'b1);
        wr(0, 31, 1'b1);
        sweep();
        checks++;
        if (sw_on + sw_off !== 0) begin
            errors++; $display("FAIL out_of_range: got on=%0d off=%0d want 0/0", sw_on, sw_off);
        end
        bank_num = 1'b1; op_num = 5'd25; sample_clk_en = 1'b1;
        @(negedge clk);
        checks++;
        if (key_on_pulse_p0 !== 1'b0 || key_off_pulse_p0 !== 1'b0 || key_state_p0 !== 1'b0) begin
            errors++; $display("FAIL oor_service: got on=%b off=%b st=%b want 0/0/0",
                               key_on_pulse_p0, key_off_pulse_p0, key_state_p0);
        end
        @(posedge clk); #1;
        sample_clk_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        wr(0, 7, 1'b1);
        wr(1, 2, 1'b1);
        wr(0, 5, 1'b1);
        wr(0, 5, 1'b0);
        // Partial sweep, then asynchronous reset between edges.
        for (int o = 0; o < 4; o++) begin
            bank_num = 1'b0; op_num = 5'(o); sample_clk_en = 1'b1;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        bank_num = 1'b0; op_num = 5'd7;
        @(negedge clk);
        checks++;
        if (key_on_pulse_p0 !== 1'b0 || key_state_p0 !== 1'b0) begin
            errors++; $display("FAIL reset_mid_hold: got on=%b st=%b want 0/0", key_on_pulse_p0, key_state_p0);
        end
        @(posedge clk); #1;
        sample_clk_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sweep();
        checks++;
        if (sw_on + sw_off !== 0) begin
            errors++; $display("FAIL reset_mid_sweep: got on=%0d off=%0d want 0/0", sw_on, sw_off);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sample_clk_en = 1'b0;
        bank_num = '0; op_num = '0;
        key_wr = 1'b0; key_wr_bank = '0; key_wr_op = '0; key_wr_val = 1'b0;
        @(posedge clk); #1;

        test_reset();
        test_key_on();
        test_key_off();
        test_on_off_burst();
        test_same_cycle();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
